adaptor_2port_pipe: RTL and testbench

ADAPTOR_2PORT_PIPE -- requirements
Module: adaptor_2port_pipe

---
 rtl/adaptor_pkg.sv | 29 ++
 rtl/adaptor_coef_bank.sv | 42 ++++
 rtl/adaptor_2port_pipe.sv | 162 ++++++++++++++++
 tb/tb_adaptor_2port_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adaptor_pkg.sv
// Shared defaults and arithmetic helpers for the two-port wave adaptor.
// Helpers work on a 64-bit signed carrier; callers size-cast the result.
package adaptor_pkg;

  localparam int D_WID_DEF = 12;
  localparam int C_WID_DEF = 11;
  localparam int N_CH_DEF  = 4;

  // Divide by 2^sh, rounding exact halves toward +infinity.
  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v,
                                                       input int sh);
    logic signed [63:0] half;
    half = 64'sd1 <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

  // Clip v into the signed range of a w-bit two's-complement word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/adaptor_coef_bank.sv
// Per-channel alpha coefficient registers with one write port and a
// combinational read by channel index. Channels outside 0..N_CH-1 are
// never written and read back as zero.
module adaptor_coef_bank import adaptor_pkg::*; #(
  parameter int C_WID = C_WID_DEF,
  parameter int N_CH  = N_CH_DEF,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_addr,
  input  logic signed [C_WID-1:0] wr_alpha,
  input  logic [CH_W-1:0]         rd_ch,
  output logic signed [C_WID-1:0] rd_alpha
);

  logic signed [C_WID-1:0] alpha_q [N_CH];
  logic [N_CH-1:0]         wr_hit;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_hit
    assign wr_hit[gi] = wr_en && (int'(wr_addr) == gi);
  end

  // Alpha registers: cleared by reset, loaded when addressed by a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) alpha_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_hit[i]) alpha_q[i] <= wr_alpha;
      end
    end
  end

  // Read the current (pre-write) alpha of the requested channel
  always_comb begin
    rd_alpha = '0;
    if (int'(rd_ch) < N_CH) rd_alpha = alpha_q[rd_ch];
  end

endmodule

// File: rtl/adaptor_2port_pipe.sv
// Three-stage pipelined two-port wave adaptor with per-channel alpha:
//   d = a2 - a1, r = round(alpha*d), b1 = a2 + r, b2 = a1 + r.
// Optional feature macro ADAPTOR_SAT_EN: saturate b1/b2 and expose a
// sticky sat_flag output; without it the outputs wrap.
module adaptor_2port_pipe import adaptor_pkg::*; #(
  parameter int D_WID = D_WID_DEF,
  parameter int C_WID = C_WID_DEF,
  parameter int N_CH  = N_CH_DEF,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [D_WID-1:0] a1,
  input  logic signed [D_WID-1:0] a2,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_addr,
  input  logic signed [C_WID-1:0] cfg_alpha,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [D_WID-1:0] b1,
  output logic signed [D_WID-1:0] b2
`ifdef ADAPTOR_SAT_EN
  ,
  output logic                    sat_flag
`endif
);

  localparam int E_WID = D_WID + 1;      // difference / widened inputs
  localparam int P_WID = C_WID + E_WID;  // full product

  logic                    advance;
  logic signed [C_WID-1:0] alpha_rd;

  logic                    s1_valid_q;
  logic [CH_W-1:0]         s1_ch_q;
  logic signed [E_WID-1:0] s1_diff_q, s1_a1_q, s1_a2_q;
  logic signed [C_WID-1:0] s1_alpha_q;

  logic                    s2_valid_q;
  logic [CH_W-1:0]         s2_ch_q;
  logic signed [P_WID-1:0] s2_prod_q;
  logic signed [E_WID-1:0] s2_a1_q, s2_a2_q;

  logic                    s3_valid_q;
  logic [CH_W-1:0]         s3_ch_q;
  logic signed [D_WID-1:0] s3_b1_q, s3_b2_q;

  logic signed [E_WID-1:0] diff_d;
  logic signed [P_WID-1:0] prod_d;
  logic signed [63:0]      r_full, sum1, sum2;
  logic signed [D_WID-1:0] b1_d, b2_d;

  // The whole pipe moves together; it only freezes when a result is
  // waiting in stage 3 and downstream refuses it.
  assign in_ready = !s3_valid_q || out_ready;
  assign advance  = in_ready;

  adaptor_coef_bank #(
    .C_WID (C_WID),
    .N_CH  (N_CH)
  ) u_coef (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (cfg_we),
    .wr_addr  (cfg_addr),
    .wr_alpha (cfg_alpha),
    .rd_ch    (in_ch),
    .rd_alpha (alpha_rd)
  );

  // Arithmetic feeding each stage register bank
  always_comb begin
    diff_d = E_WID'(a2) - E_WID'(a1);
    prod_d = P_WID'(s1_alpha_q) * P_WID'(s1_diff_q);
    r_full = round_half_up(64'(s2_prod_q), C_WID - 1);
    sum1   = 64'(s2_a2_q) + r_full;
    sum2   = 64'(s2_a1_q) + r_full;
`ifdef ADAPTOR_SAT_EN
    b1_d   = D_WID'(saturate(sum1, D_WID));
    b2_d   = D_WID'(saturate(sum2, D_WID));
`else
    b1_d   = D_WID'(sum1);
    b2_d   = D_WID'(sum2);
`endif
  end

  // Stage 1: difference, channel alpha and widened inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_diff_q  <= '0;
      s1_a1_q    <= '0;
      s1_a2_q    <= '0;
      s1_alpha_q <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_ch_q    <= in_ch;
      s1_diff_q  <= diff_d;
      s1_a1_q    <= E_WID'(a1);
      s1_a2_q    <= E_WID'(a2);
      s1_alpha_q <= alpha_rd;
    end
  end

  // Stage 2: full-precision product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_ch_q    <= '0;
      s2_prod_q  <= '0;
      s2_a1_q    <= '0;
      s2_a2_q    <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_ch_q    <= s1_ch_q;
      s2_prod_q  <= prod_d;
      s2_a1_q    <= s1_a1_q;
      s2_a2_q    <= s1_a2_q;
    end
  end

  // Stage 3: rounded, range-limited reflected waves held for downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_ch_q    <= '0;
      s3_b1_q    <= '0;
      s3_b2_q    <= '0;
    end else if (advance) begin
      s3_valid_q <= s2_valid_q;
      s3_ch_q    <= s2_ch_q;
      s3_b1_q    <= b1_d;
      s3_b2_q    <= b2_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_ch    = s3_ch_q;
  assign b1        = s3_b1_q;
  assign b2        = s3_b2_q;

`ifdef ADAPTOR_SAT_EN
  logic sat_hit;
  logic sat_q;

  assign sat_hit = s2_valid_q && ((sum1 != 64'(b1_d)) || (sum2 != 64'(b2_d)));

  // Sticky record of any real sample that clipped on its way into stage 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  sat_q <= 1'b0;
    else if (advance && sat_hit) sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_adaptor_2port_pipe.sv
// Self-checking bench for adaptor_2port_pipe (D_WID=12, C_WID=11, N_CH=4).
// A queue-based model predicts each result at acceptance; one monitor
// compares every cycle. Directed tests add hand-computed literal checks.
module tb_adaptor_2port_pipe;

  localparam int D_WID = 12;
  localparam int C_WID = 11;
  localparam int N_CH  = 4;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, cfg_we, out_valid, out_ready;
  logic [1:0] in_ch, cfg_addr, out_ch;
  logic signed [D_WID-1:0] a1, a2, b1, b2;
  logic signed [C_WID-1:0] cfg_alpha;
`ifdef ADAPTOR_SAT_EN
  logic sat_flag;
`endif

  always #5 clk = ~clk;

  adaptor_2port_pipe #(.D_WID(D_WID), .C_WID(C_WID), .N_CH(N_CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .a1(a1), .a2(a2),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_alpha(cfg_alpha),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .b1(b1), .b2(b2)
`ifdef ADAPTOR_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  typedef struct {
    int ch; int b1; int b2; bit sat; int acc; int st; bit seen;
  } exp_t;

  exp_t expq[$];
  int   model_alpha[N_CH];
  bit   sat_seen = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   ncyc = 0;
  int   stall_cnt = 0;
  bit   pat_on = 1'b0;
  logic [7:0] pat = 8'b1011_0110;

  function automatic void check(input string nm, input logic signed [63:0] act,
                                input logic signed [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Floor division for a positive divisor
  function automatic longint floor_div(input longint n, input longint den);
    longint q;
    q = n / den;
    if ((n % den != 0) && (n < 0)) q = q - 1;
    return q;
  endfunction

  // Bring a mathematically exact result into the D_WID output range
  function automatic int fit(input longint v, output bit clipped);
    longint lim, m;
    lim = longint'(1) << (D_WID - 1);
    clipped = 1'b0;
    m = v;
`ifdef ADAPTOR_SAT_EN
    if (v > lim - 1) begin clipped = 1'b1; m = lim - 1; end
    if (v < -lim)    begin clipped = 1'b1; m = -lim;    end
`else
    m = v % (2 * lim);
    if (m < 0) m = m + 2 * lim;
    if (m >= lim) m = m - 2 * lim;
`endif
    return int'(m);
  endfunction

  function automatic exp_t model(input int ch, input int x1, input int x2);
    exp_t   e;
    longint d, r;
    bit     c1, c2;
    d = longint'(x2) - longint'(x1);
    r = floor_div(longint'(model_alpha[ch]) * d + (longint'(1) << (C_WID - 2)),
                  longint'(1) << (C_WID - 1));
    e.ch   = ch;
    e.b1   = fit(longint'(x2) + r, c1);
    e.b2   = fit(longint'(x1) + r, c2);
    e.sat  = c1 | c2;
    e.acc  = 0;
    e.st   = 0;
    e.seen = 1'b0;
    return e;
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will do
  initial begin
    bit held;
    int h_b1, h_b2, h_ch;
    exp_t e;
    held = 1'b0; h_b1 = 0; h_b2 = 0; h_ch = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        expq.delete();
        for (int i = 0; i < N_CH; i++) model_alpha[i] = 0;
        sat_seen = 1'b0;
        held = 1'b0;
        check("reset_out_valid", out_valid, 0);
        check("reset_b1", b1, 0);
        check("reset_b2", b2, 0);
        check("reset_out_ch", out_ch, 0);
`ifdef ADAPTOR_SAT_EN
        check("reset_sat_flag", sat_flag, 0);
`endif
      end else begin
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (held) begin
          check("hold_valid", out_valid, 1);
          check("hold_b1", b1, h_b1);
          check("hold_b2", b2, h_b2);
          check("hold_ch", out_ch, h_ch);
        end
        if (out_valid && expq.size() == 0) check("spurious_out", out_valid, 0);
        if (out_valid && expq.size() != 0) begin
          e = expq[0];
          if (!e.seen) begin
            check("latency", ncyc, e.acc + 3 + (stall_cnt - e.st));
            expq[0].seen = 1'b1;
          end
          if (out_ready) begin
            check("out_ch", out_ch, e.ch);
            check("out_b1", b1, e.b1);
            check("out_b2", b2, e.b2);
`ifdef ADAPTOR_SAT_EN
            sat_seen = sat_seen | e.sat;
            check("sat_flag", sat_flag, sat_seen);
`endif
            void'(expq.pop_front());
          end
        end
        held = out_valid && !out_ready;
        h_b1 = int'(b1); h_b2 = int'(b2); h_ch = int'(out_ch);
        if (!in_ready) stall_cnt++;
        if (in_valid && in_ready) begin
          e = model(int'(in_ch), int'(a1), int'(a2));
          e.acc = ncyc;
          e.st  = stall_cnt;
          expq.push_back(e);
        end
        if (cfg_we && int'(cfg_addr) < N_CH) model_alpha[cfg_addr] = int'(cfg_alpha);
      end
    end
  end

  // Background out_ready pattern used for the mixed-traffic table
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk); #1;
      if (pat_on) out_ready = pat[k % 8];
      k++;
    end
  end

  // All stimulus tasks start and end just after a rising edge
  task automatic send(input int ch, input int x1, input int x2);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_ch = 2'(ch); a1 = D_WID'(x1); a2 = D_WID'(x2);
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) check("send_timeout", guard, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg(input int ch, input int alpha);
    cfg_we = 1'b1; cfg_addr = 2'(ch); cfg_alpha = C_WID'(alpha);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_out(input string nm, input int e1, input int e2, input int lat);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!(out_valid && out_ready) && k < 20);
    check({nm, "_timeout"}, (k < 20) ? 1 : 0, 1);
    check({nm, "_b1"}, b1, e1);
    check({nm, "_b2"}, b2, e2);
    if (lat > 0) check({nm, "_lat"}, k, lat);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (expq.size() != 0 && k < 200) begin @(negedge clk); k++; end
    check({nm, "_empty"}, expq.size(), 0);
    @(posedge clk); #1;
  endtask

  int tch[8] = '{0, 1, 2, 3, 0, 2, 3, 1};
  int ta1[8] = '{-2048, 2047, -1000, 555, 0, 2047, -2048, -1};
  int ta2[8] = '{-2048, -2048, 1000, -555, 0, -2048, 2047, 1};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; a1 = '0; a2 = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_alpha = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_reset", in_ready, 1);
    @(posedge clk); #1;

    cfg(0, 512); cfg(1, 1); cfg(2, 1023);

    send(0, 100, 300);     wait_out("t038", 400, 200, 3);
    send(1, 0, 512);       wait_out("t039", 513, 1, 0);
    send(2, -2048, 2047);
`ifdef ADAPTOR_SAT_EN
    wait_out("t040", 2047, 2043, 0);
    check("t040_sat", sat_flag, 1);
`else
    wait_out("t040", 2042, 2043, 0);
`endif

    // Same-cycle write and sample on channel 3: old alpha (0) applies
    in_valid = 1'b1; in_ch = 2'd3; a1 = 12'sd10; a2 = 12'sd50;
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_alpha = -11'sd1024;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    wait_out("t042_old", 50, 10, 0);
    send(3, 10, 50);       wait_out("t042_new", 10, -30, 0);

    // Back-to-back samples into a stalled output, with a write mid-stall
    out_ready = 1'b0;
    send(0, 40, -60); send(1, 7, 9); send(3, -100, 100);
    for (int i = 0; i < 5; i++) begin
      cfg_we = (i == 2); cfg_addr = 2'd1; cfg_alpha = -11'sd512;
      @(negedge clk);
      check("t041_stall_rdy", in_ready, 0);
      if (i == 0) begin
        check("t041_head_ch", out_ch, 0);
        check("t041_head_b1", b1, -110);
        check("t041_head_b2", b2, -10);
      end
      @(posedge clk); #1;
    end
    cfg_we = 1'b0; out_ready = 1'b1;
    drain("t041");
    send(1, 0, 100);       wait_out("t026_stall_cfg", 50, -50, 0);

    // Mixed traffic with a toggling out_ready
    cfg(3, -300);
    pat_on = 1'b1;
    for (int i = 0; i < 8; i++) send(tch[i], ta1[i], ta2[i]);
    drain("table");
    pat_on = 1'b0; out_ready = 1'b1;

    // Reset with two samples in flight
    send(0, 1, 2); send(1, 3, 4);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t043_rdy", in_ready, 1);
    check("t043_ovalid", out_valid, 0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    send(2, -5, 20);       wait_out("t043_alpha0", 20, -5, 0);
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
